// File: rtl/unary16_checker.sv
// unary16_checker: self-test engine for 16-bit unary bitwise chips (not16 by default).
// Drives a fixed 20-vector sequence on stim_out, holds each vector SETTLE cycles,
// then compares resp_in against stim_out ^ INV_MASK and accumulates the results.
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           pulse; begins a run when not busy
//   stim_out[15:0]  vector driven to the chip under test
//   resp_in[15:0]   chip response, combinational function of stim_out
//   busy            run in progress
//   done            sticky after a run completes, cleared by the next accepted start
//   pass            done with zero mismatches
//   err_count[4:0]  mismatched vectors in the current/last run (0..20)
//   first_fail_idx  index of the first mismatching vector, 31 if none
//   first_fail_resp resp_in captured at the first mismatch, 0 if none
module unary16_checker #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] INV_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] stim_out,
    input  logic [15:0] resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [4:0]  first_fail_idx,
    output logic [15:0] first_fail_resp
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [4:0] LAST_IDX = 5'd19;
    localparam logic [4:0] MAX_ERR  = 5'd20;
    localparam logic [4:0] NO_FAIL  = 5'd31;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stim_q, stim_d;
    logic [4:0]  err_q, err_d;
    logic [4:0]  ffi_q, ffi_d;
    logic [15:0] ffr_q, ffr_d;
    logic        mismatch;

    // Vector ROM: four fixed patterns, then a walking one from bit 0 to bit 15.
    function automatic logic [15:0] vec(input logic [4:0] i);
        vec = i == 5'd0 ? 16'h0000 :
              i == 5'd1 ? 16'hFFFF :
              i == 5'd2 ? 16'hAAAA :
              i == 5'd3 ? 16'h5555 : 16'h0001 << (i - 5'd4);
    endfunction

    assign mismatch = resp_in != (stim_q ^ INV_MASK);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffr_d   = ffr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 5'd0;
                    cnt_d   = SETTLE_C;
                    stim_d  = vec(5'd0);
                    err_d   = 5'd0;
                    ffi_d   = NO_FAIL;
                    ffr_d   = 16'h0000;
                end
            end
            DRIVE: begin
                // Counter is loaded with SETTLE, so leaving at 1 gives exactly SETTLE cycles here.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q < MAX_ERR ? err_q + 5'd1 : err_q;
                    if (err_q == 5'd0) begin
                        ffi_d = idx_q;
                        ffr_d = resp_in;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 5'd1;
                    cnt_d   = SETTLE_C;
                    stim_d  = vec(idx_q + 5'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= 4'd0;
            stim_q  <= 16'h0000;
            err_q   <= 5'd0;
            ffi_q   <= NO_FAIL;
            ffr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffr_q   <= ffr_d;
        end
    end

    assign stim_out        = stim_q;
    assign busy            = state_q == DRIVE || state_q == CHECK;
    assign done            = state_q == DONE;
    assign pass            = done && err_q == 5'd0;
    assign err_count       = err_q;
    assign first_fail_idx  = ffi_q;
    assign first_fail_resp = ffr_q;
endmodule

// File: tb/tb_unary16_checker.sv
// tb_unary16_checker: directed bench for unary16_checker (inverter and buffer builds).
module tb_unary16_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode_a = 3'd0;
    logic        mode_b = 1'b0;
    logic [15:0] stim_a, resp_a, ffr_a, stim_b, resp_b, ffr_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [4:0]  err_a, ffi_a, err_b, ffi_b;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [2:0]  mode_a;
        logic        mode_b;
        logic        poke;
        logic [4:0]  err_a, ffi_a;
        logic [15:0] ffr_a;
        logic        pass_a;
        logic [4:0]  err_b, ffi_b;
        logic [15:0] ffr_b;
        logic        pass_b;
    } rec_t;

    logic [15:0] vec_m [20] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555,
                                16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                16'h0010, 16'h0020, 16'h0040, 16'h0080,
                                16'h0100, 16'h0200, 16'h0400, 16'h0800,
                                16'h1000, 16'h2000, 16'h4000, 16'h8000};
    rec_t recs [5];

    always #5 clk = ~clk;

    // Modelled chips: 0 good not16, 1 bit3 stuck-at-0, 2 bit0 stuck-at-1,
    // 3 buffer instead of inverter, 4 bit0 wrong only on the last vector.
    always_comb begin
        case (mode_a)
            3'd0:    resp_a = ~stim_a;
            3'd1:    resp_a = ~stim_a & 16'hFFF7;
            3'd2:    resp_a = ~stim_a | 16'h0001;
            3'd3:    resp_a = stim_a;
            default: resp_a = ~stim_a ^ (stim_a == 16'h8000 ? 16'h0001 : 16'h0000);
        endcase
        resp_b = mode_b ? ~stim_b : stim_b;
    end

    unary16_checker u_inv (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_out(stim_a), .resp_in(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_idx(ffi_a), .first_fail_resp(ffr_a));

    unary16_checker #(.SETTLE(1), .INV_MASK(16'h0000)) u_buf (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_out(stim_b), .resp_in(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_idx(ffi_b), .first_fail_resp(ffr_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input rec_t r);
        int cyc;
        int seq;
        mode_a = r.mode_a;
        mode_b = r.mode_b;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("acc_busy", busy_a, 1);
        chk("acc_done", done_a, 0);
        chk("acc_err", err_a, 0);
        chk("acc_ffi", ffi_a, 31);
        chk("acc_ffr", ffr_a, 0);
        cyc = 0;
        seq = int'(stim_a != vec_m[0]);
        while (!done_a && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (r.poke) start = (cyc == 10);
            if (cyc < 40 && stim_a != vec_m[cyc / 2]) seq++;
        end
        start = 1'b0;
        chk("latency", cyc, 40);
        chk("stim_seq_errs", seq, 0);
        chk("last_stim", stim_a, 16'h8000);
        chk("busy_end", busy_a, 0);
        chk("err_a", err_a, r.err_a);
        chk("ffi_a", ffi_a, r.ffi_a);
        chk("ffr_a", ffr_a, r.ffr_a);
        chk("pass_a", pass_a, r.pass_a);
        chk("done_b", done_b, 1);
        chk("err_b", err_b, r.err_b);
        chk("ffi_b", ffi_b, r.ffi_b);
        chk("ffr_b", ffr_b, r.ffr_b);
        chk("pass_b", pass_b, r.pass_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_err;
        recs[0] = '{3'd0, 1'b0, 1'b0, 5'd0,  5'd31, 16'h0000, 1'b1, 5'd0,  5'd31, 16'h0000, 1'b1};
        recs[1] = '{3'd1, 1'b1, 1'b0, 5'd17, 5'd0,  16'hFFF7, 1'b0, 5'd20, 5'd0,  16'hFFFF, 1'b0};
        recs[2] = '{3'd2, 1'b0, 1'b1, 5'd3,  5'd1,  16'h0001, 1'b0, 5'd0,  5'd31, 16'h0000, 1'b1};
        recs[3] = '{3'd3, 1'b1, 1'b0, 5'd20, 5'd0,  16'h0000, 1'b0, 5'd20, 5'd0,  16'hFFFF, 1'b0};
        recs[4] = '{3'd4, 1'b0, 1'b0, 5'd1,  5'd19, 16'h7FFE, 1'b0, 5'd0,  5'd31, 16'h0000, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stim", stim_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ffi", ffi_a, 31);
        chk("rst_ffr", ffr_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (stim_a != 16'h0 || busy_a || done_a || ffi_a != 5'd31 || err_a != 5'd0) idle_err++;
        end
        chk("idle_hold_errs", idle_err, 0);

        for (int i = 0; i < 5; i++) run(recs[i]);

        // Abort mid-run (idx 9) with a faulty chip so results are nonzero before reset.
        mode_a = 3'd1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("mid_stim_idx9", stim_a, 16'h0020);
        chk("mid_err_nonzero", err_a != 5'd0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stim", stim_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_err", err_a, 0);
        chk("arst_ffi", ffi_a, 31);
        chk("arst_ffr", ffr_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(recs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
